wb_arbiter_4: RTL and testbench

//  Wishbone 4-master -> 1-slave arbiter. Several bus initiators (instruction fetch, load/store, debug, DMA)

---
 rtl/wb_arb_pkg.sv | 14 +
 rtl/wb_rr_pick.sv | 23 ++
 rtl/wb_arbiter_4.sv | 209 ++++++++++++++++++++
 tb/tb_wb_arbiter_4.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone round-robin arbiters.
package wb_arb_pkg;

  localparam int ARB_NUM_MASTERS = 4;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;
  typedef logic [1:0] arb_idx_t;

  // Master index reached by stepping 'off' places past 'base', wrapping at 4.
  function automatic arb_idx_t arb_rr_next(input arb_idx_t base, input int unsigned off);
    return arb_idx_t'(base + arb_idx_t'(off));
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first requester after last_idx, wrapping.
module wb_rr_pick
  import wb_arb_pkg::*;
(
  input  logic [ARB_NUM_MASTERS-1:0] req,
  input  arb_idx_t                   last_idx,
  output logic                       valid,
  output arb_idx_t                   idx
);

  // Scan last_idx+1 .. last_idx+4 and keep the first active request.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int unsigned off = 1; off <= ARB_NUM_MASTERS; off++) begin
      if (!valid && req[arb_rr_next(last_idx, off)]) begin
        valid = 1'b1;
        idx   = arb_rr_next(last_idx, off);
      end
    end
  end

endmodule

// File: rtl/wb_arbiter_4.sv
// Wishbone 4-master -> 1-slave round-robin arbiter. A grant is held for the
// whole master cycle (cyc_i high); one dead IDLE cycle separates tenures.
// Optional slave watchdog: define WB_ARB_TIMEOUT_EN.
module wb_arbiter_4
  import wb_arb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int SELECT_WIDTH   = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic [ADDR_WIDTH-1:0]   wb_master0_adr_i,
  input  logic [DATA_WIDTH-1:0]   wb_master0_dat_i,
  output logic [DATA_WIDTH-1:0]   wb_master0_dat_o,
  input  logic                    wb_master0_we_i,
  input  logic [SELECT_WIDTH-1:0] wb_master0_sel_i,
  input  logic                    wb_master0_stb_i,
  input  logic                    wb_master0_cyc_i,
  output logic                    wb_master0_ack_o,
  output logic                    wb_master0_err_o,
  output logic                    wb_master0_rty_o,

  input  logic [ADDR_WIDTH-1:0]   wb_master1_adr_i,
  input  logic [DATA_WIDTH-1:0]   wb_master1_dat_i,
  output logic [DATA_WIDTH-1:0]   wb_master1_dat_o,
  input  logic                    wb_master1_we_i,
  input  logic [SELECT_WIDTH-1:0] wb_master1_sel_i,
  input  logic                    wb_master1_stb_i,
  input  logic                    wb_master1_cyc_i,
  output logic                    wb_master1_ack_o,
  output logic                    wb_master1_err_o,
  output logic                    wb_master1_rty_o,

  input  logic [ADDR_WIDTH-1:0]   wb_master2_adr_i,
  input  logic [DATA_WIDTH-1:0]   wb_master2_dat_i,
  output logic [DATA_WIDTH-1:0]   wb_master2_dat_o,
  input  logic                    wb_master2_we_i,
  input  logic [SELECT_WIDTH-1:0] wb_master2_sel_i,
  input  logic                    wb_master2_stb_i,
  input  logic                    wb_master2_cyc_i,
  output logic                    wb_master2_ack_o,
  output logic                    wb_master2_err_o,
  output logic                    wb_master2_rty_o,

  input  logic [ADDR_WIDTH-1:0]   wb_master3_adr_i,
  input  logic [DATA_WIDTH-1:0]   wb_master3_dat_i,
  output logic [DATA_WIDTH-1:0]   wb_master3_dat_o,
  input  logic                    wb_master3_we_i,
  input  logic [SELECT_WIDTH-1:0] wb_master3_sel_i,
  input  logic                    wb_master3_stb_i,
  input  logic                    wb_master3_cyc_i,
  output logic                    wb_master3_ack_o,
  output logic                    wb_master3_err_o,
  output logic                    wb_master3_rty_o,

  output logic [ADDR_WIDTH-1:0]   wb_slave_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_slave_dat_o,
  output logic                    wb_slave_we_o,
  output logic [SELECT_WIDTH-1:0] wb_slave_sel_o,
  output logic                    wb_slave_stb_o,
  output logic                    wb_slave_cyc_o,
  input  logic [DATA_WIDTH-1:0]   wb_slave_dat_i,
  input  logic                    wb_slave_ack_i,
  input  logic                    wb_slave_err_i,
  input  logic                    wb_slave_rty_i
);

  logic [ARB_NUM_MASTERS-1:0][ADDR_WIDTH-1:0]   m_adr;
  logic [ARB_NUM_MASTERS-1:0][DATA_WIDTH-1:0]   m_dat_i;
  logic [ARB_NUM_MASTERS-1:0][SELECT_WIDTH-1:0] m_sel;
  logic [ARB_NUM_MASTERS-1:0]                   m_we;
  logic [ARB_NUM_MASTERS-1:0]                   m_stb;
  logic [ARB_NUM_MASTERS-1:0]                   m_cyc;
  logic [ARB_NUM_MASTERS-1:0][DATA_WIDTH-1:0]   m_dat_o;
  logic [ARB_NUM_MASTERS-1:0]                   m_ack;
  logic [ARB_NUM_MASTERS-1:0]                   m_err;
  logic [ARB_NUM_MASTERS-1:0]                   m_rty;

  arb_state_t state, state_nxt;
  arb_idx_t   grant_idx, grant_nxt;
  arb_idx_t   last_idx, last_nxt;
  logic       pick_valid;
  arb_idx_t   pick_idx;
  logic       granted;
  logic       stall;
  logic       to_fire;

  assign m_adr   = {wb_master3_adr_i, wb_master2_adr_i, wb_master1_adr_i, wb_master0_adr_i};
  assign m_dat_i = {wb_master3_dat_i, wb_master2_dat_i, wb_master1_dat_i, wb_master0_dat_i};
  assign m_sel   = {wb_master3_sel_i, wb_master2_sel_i, wb_master1_sel_i, wb_master0_sel_i};
  assign m_we    = {wb_master3_we_i,  wb_master2_we_i,  wb_master1_we_i,  wb_master0_we_i};
  assign m_stb   = {wb_master3_stb_i, wb_master2_stb_i, wb_master1_stb_i, wb_master0_stb_i};
  assign m_cyc   = {wb_master3_cyc_i, wb_master2_cyc_i, wb_master1_cyc_i, wb_master0_cyc_i};

  assign wb_master0_dat_o = m_dat_o[0];
  assign wb_master1_dat_o = m_dat_o[1];
  assign wb_master2_dat_o = m_dat_o[2];
  assign wb_master3_dat_o = m_dat_o[3];
  assign wb_master0_ack_o = m_ack[0];
  assign wb_master1_ack_o = m_ack[1];
  assign wb_master2_ack_o = m_ack[2];
  assign wb_master3_ack_o = m_ack[3];
  assign wb_master0_err_o = m_err[0];
  assign wb_master1_err_o = m_err[1];
  assign wb_master2_err_o = m_err[2];
  assign wb_master3_err_o = m_err[3];
  assign wb_master0_rty_o = m_rty[0];
  assign wb_master1_rty_o = m_rty[1];
  assign wb_master2_rty_o = m_rty[2];
  assign wb_master3_rty_o = m_rty[3];

  wb_rr_pick u_pick (
    .req      (m_cyc),
    .last_idx (last_idx),
    .valid    (pick_valid),
    .idx      (pick_idx)
  );

  // Outputs are gated by rst_n as well as state so they drop the instant reset asserts.
  assign granted = rst_n && (state == ARB_GRANT);
  assign stall   = granted && m_cyc[grant_idx] && m_stb[grant_idx] &&
                   !(wb_slave_ack_i || wb_slave_err_i || wb_slave_rty_i);

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] to_cnt;

  assign to_fire = stall && (to_cnt == TO_LIMIT);

  // Count consecutive stalled strobe cycles; any response, idle strobe or a fired timeout clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (stall && !to_fire) begin
      to_cnt <= to_cnt + 16'd1;
    end else begin
      to_cnt <= '0;
    end
  end
`else
  // No watchdog: the limit is at least 1, so this is constant low.
  assign to_fire = (TIMEOUT_CYCLES == 0);
`endif

  // Arbiter state and grant registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      grant_idx <= '0;
      last_idx  <= 2'd3;
    end else begin
      state     <= state_nxt;
      grant_idx <= grant_nxt;
      last_idx  <= last_nxt;
    end
  end

  // Next state: grant on any request in IDLE, release when the owner drops cyc.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant_idx;
    last_nxt  = last_idx;
    case (state)
      ARB_IDLE: begin
        if (pick_valid) begin
          grant_nxt = pick_idx;
          state_nxt = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (!m_cyc[grant_idx]) begin
          last_nxt  = grant_idx;
          state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Route the owner's request to the slave and the slave's response back to the owner only.
  always_comb begin
    wb_slave_adr_o = '0;
    wb_slave_dat_o = '0;
    wb_slave_we_o  = 1'b0;
    wb_slave_sel_o = '0;
    wb_slave_stb_o = 1'b0;
    wb_slave_cyc_o = 1'b0;
    m_dat_o        = '0;
    m_ack          = '0;
    m_err          = '0;
    m_rty          = '0;
    if (granted) begin
      wb_slave_adr_o     = m_adr[grant_idx];
      wb_slave_dat_o     = m_dat_i[grant_idx];
      wb_slave_we_o      = m_we[grant_idx];
      wb_slave_sel_o     = m_sel[grant_idx];
      wb_slave_cyc_o     = m_cyc[grant_idx] && !to_fire;
      wb_slave_stb_o     = m_cyc[grant_idx] && m_stb[grant_idx] && !to_fire;
      m_dat_o[grant_idx] = wb_slave_dat_i;
      m_ack[grant_idx]   = wb_slave_ack_i;
      m_err[grant_idx]   = wb_slave_err_i || to_fire;
      m_rty[grant_idx]   = wb_slave_rty_i;
    end
  end

endmodule

// File: tb/tb_wb_arbiter_4.sv
// Self-checking bench for wb_arbiter_4: vector table, directed corner cases,
// randomized traffic against a behavioural reference model.
module tb_wb_arbiter_4;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] m_adr   [4];
  logic [DW-1:0] m_dat_i [4];
  logic [DW-1:0] m_dat_o [4];
  logic          m_we    [4];
  logic [SW-1:0] m_sel   [4];
  logic          m_stb   [4];
  logic          m_cyc   [4];
  logic          m_ack   [4];
  logic          m_err   [4];
  logic          m_rty   [4];
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_dat_o, s_dat_i;
  logic          s_we, s_stb, s_cyc, s_ack, s_err, s_rty;
  logic [SW-1:0] s_sel;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_arbiter_4 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_master0_adr_i(m_adr[0]), .wb_master0_dat_i(m_dat_i[0]), .wb_master0_dat_o(m_dat_o[0]),
    .wb_master0_we_i(m_we[0]), .wb_master0_sel_i(m_sel[0]), .wb_master0_stb_i(m_stb[0]),
    .wb_master0_cyc_i(m_cyc[0]), .wb_master0_ack_o(m_ack[0]), .wb_master0_err_o(m_err[0]),
    .wb_master0_rty_o(m_rty[0]),
    .wb_master1_adr_i(m_adr[1]), .wb_master1_dat_i(m_dat_i[1]), .wb_master1_dat_o(m_dat_o[1]),
    .wb_master1_we_i(m_we[1]), .wb_master1_sel_i(m_sel[1]), .wb_master1_stb_i(m_stb[1]),
    .wb_master1_cyc_i(m_cyc[1]), .wb_master1_ack_o(m_ack[1]), .wb_master1_err_o(m_err[1]),
    .wb_master1_rty_o(m_rty[1]),
    .wb_master2_adr_i(m_adr[2]), .wb_master2_dat_i(m_dat_i[2]), .wb_master2_dat_o(m_dat_o[2]),
    .wb_master2_we_i(m_we[2]), .wb_master2_sel_i(m_sel[2]), .wb_master2_stb_i(m_stb[2]),
    .wb_master2_cyc_i(m_cyc[2]), .wb_master2_ack_o(m_ack[2]), .wb_master2_err_o(m_err[2]),
    .wb_master2_rty_o(m_rty[2]),
    .wb_master3_adr_i(m_adr[3]), .wb_master3_dat_i(m_dat_i[3]), .wb_master3_dat_o(m_dat_o[3]),
    .wb_master3_we_i(m_we[3]), .wb_master3_sel_i(m_sel[3]), .wb_master3_stb_i(m_stb[3]),
    .wb_master3_cyc_i(m_cyc[3]), .wb_master3_ack_o(m_ack[3]), .wb_master3_err_o(m_err[3]),
    .wb_master3_rty_o(m_rty[3]),
    .wb_slave_adr_o(s_adr), .wb_slave_dat_o(s_dat_o), .wb_slave_we_o(s_we),
    .wb_slave_sel_o(s_sel), .wb_slave_stb_o(s_stb), .wb_slave_cyc_o(s_cyc),
    .wb_slave_dat_i(s_dat_i), .wb_slave_ack_i(s_ack), .wb_slave_err_i(s_err),
    .wb_slave_rty_i(s_rty)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] ack_vec();
    return {m_ack[3], m_ack[2], m_ack[1], m_ack[0]};
  endfunction
  function automatic logic [3:0] err_vec();
    return {m_err[3], m_err[2], m_err[1], m_err[0]};
  endfunction
  function automatic logic [3:0] rty_vec();
    return {m_rty[3], m_rty[2], m_rty[1], m_rty[0]};
  endfunction

  function automatic logic any_output();
    logic r;
    r = (|s_adr) | (|s_dat_o) | s_we | (|s_sel) | s_stb | s_cyc;
    for (int i = 0; i < 4; i++) r = r | (|m_dat_o[i]) | m_ack[i] | m_err[i] | m_rty[i];
    return r;
  endfunction

  task automatic idle_inputs();
    for (int i = 0; i < 4; i++) begin
      m_adr[i]   = AW'(32'h100 * (i + 1));
      m_dat_i[i] = DW'(32'h1111_1111 * (i + 1));
      m_we[i]    = 1'b0;
      m_sel[i]   = '1;
      m_stb[i]   = 1'b0;
      m_cyc[i]   = 1'b0;
    end
    s_dat_i = '0;
    s_ack   = 1'b0;
    s_err   = 1'b0;
    s_rty   = 1'b0;
  endtask

  // ---------------- reference model ----------------
  int owner;   // master holding the bus, -1 when none
  int last;    // master that held it most recently
  int stalled; // consecutive strobe cycles without a slave response

  task automatic model_reset();
    owner   = -1;
    last    = 3;
    stalled = 0;
  endtask

  function automatic bit model_fire();
`ifdef WB_ARB_TIMEOUT_EN
    if (owner < 0 || !rst_n) return 1'b0;
    return m_cyc[owner] && m_stb[owner] && !(s_ack || s_err || s_rty) && stalled == TO - 1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_check();
    logic          e_cyc = 1'b0, e_stb = 1'b0, e_we = 1'b0;
    logic [AW-1:0] e_adr = '0;
    logic [DW-1:0] e_dat = '0;
    logic [SW-1:0] e_sel = '0;
    logic [3:0]    e_ack = '0, e_err = '0, e_rty = '0;
    bit f;
    f = model_fire();
    if (rst_n && owner >= 0) begin
      e_cyc = m_cyc[owner] && !f;
      e_stb = m_cyc[owner] && m_stb[owner] && !f;
      e_adr = m_adr[owner];
      e_dat = m_dat_i[owner];
      e_we  = m_we[owner];
      e_sel = m_sel[owner];
      e_ack[owner] = s_ack;
      e_err[owner] = s_err || f;
      e_rty[owner] = s_rty;
    end
    chk("rnd_slave_cyc", s_cyc, e_cyc);
    chk("rnd_slave_stb", s_stb, e_stb);
    chk("rnd_slave_req", {s_adr, s_we, s_sel}, {e_adr, e_we, e_sel});
    chk("rnd_slave_dat", s_dat_o, e_dat);
    chk("rnd_master_resp", {ack_vec(), err_vec(), rty_vec()}, {e_ack, e_err, e_rty});
    for (int j = 0; j < 4; j++)
      chk("rnd_master_dat", m_dat_o[j], (rst_n && owner == j) ? s_dat_i : '0);
  endtask

  // Advance the model across one rising edge using the inputs present before it.
  task automatic model_step();
    bit f;
    f = model_fire();
    if (!rst_n) begin
      model_reset();
    end else if (owner < 0) begin
      for (int k = 1; k <= 4; k++) begin
        if (owner < 0 && m_cyc[(last + k) % 4]) owner = (last + k) % 4;
      end
      stalled = 0;
    end else begin
      if (m_cyc[owner] && m_stb[owner] && !(s_ack || s_err || s_rty) && !f) stalled++;
      else stalled = 0;
      if (!m_cyc[owner]) begin
        last  = owner;
        owner = -1;
      end
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit         rst;
    logic [3:0] cyc;     // cyc and stb driven together
    logic       ack;
    logic       exp_cyc; // expected slave cyc_o/stb_o
    int         exp_g;   // master whose request is on the slave bus, -1 for none
    logic [3:0] exp_ack;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, logic [3:0] c, logic a, logic ec, int g, logic [3:0] ea);
    vec_t v;
    v.rst = r; v.cyc = c; v.ack = a; v.exp_cyc = ec; v.exp_g = g; v.exp_ack = ea;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int gseq[5];
    int hang;
    int r;
    logic [3:0] one;
    gseq = '{0, 1, 2, 3, 0};

    // master 0 and 2 together: 0 first, then 2 after a dead cycle
    tbl.push_back(mk(0, 4'b0101, 0, 0, -1, 4'b0000));
    tbl.push_back(mk(0, 4'b0101, 1, 1,  0, 4'b0001));
    tbl.push_back(mk(0, 4'b0100, 0, 0,  0, 4'b0000));
    tbl.push_back(mk(0, 4'b0100, 0, 0, -1, 4'b0000));
    tbl.push_back(mk(0, 4'b0100, 1, 1,  2, 4'b0100));
    tbl.push_back(mk(0, 4'b0000, 0, 0,  2, 4'b0000));
    tbl.push_back(mk(1, 4'b0000, 0, 0, -1, 4'b0000));
    // all four requesting: one beat each, rotation 0,1,2,3,0
    foreach (gseq[i]) begin
      one = 4'b0001 << gseq[i];
      tbl.push_back(mk(0, 4'b1111, 0, 0, -1, 4'b0000));
      tbl.push_back(mk(0, 4'b1111, 1, 1, gseq[i], one));
      tbl.push_back(mk(0, 4'b1111 & ~one, 0, 0, gseq[i], 4'b0000));
    end

    do_reset();
    chk("reset_outputs_zero", any_output(), 1'b0);
    foreach (tbl[i]) begin
      rst_n = !tbl[i].rst;
      for (int j = 0; j < 4; j++) begin
        m_cyc[j] = tbl[i].cyc[j];
        m_stb[j] = tbl[i].cyc[j];
      end
      s_ack   = tbl[i].ack;
      s_dat_i = DW'(32'hC0DE_0000 + i);
      #1;
      chk("tbl_slave_cyc", s_cyc, tbl[i].exp_cyc);
      chk("tbl_slave_stb", s_stb, tbl[i].exp_cyc);
      chk("tbl_slave_adr", s_adr, (tbl[i].exp_g < 0) ? '0 : m_adr[tbl[i].exp_g]);
      chk("tbl_master_ack", ack_vec(), tbl[i].exp_ack);
      for (int j = 0; j < 4; j++)
        chk("tbl_master_dat", m_dat_o[j], (tbl[i].exp_g == j) ? s_dat_i : '0);
      tick();
    end
    rst_n = 1'b1;

    // burst by master 1 while master 3 waits
    do_reset();
    m_cyc[1] = 1; m_stb[1] = 1; m_cyc[3] = 1; m_stb[3] = 1;
    #1 chk("burst_idle_first", s_cyc, 1'b0);
    tick();
    for (int b = 1; b <= 4; b++) begin
      s_ack = 1; s_dat_i = DW'(32'hA5A5_0000 + b);
      #1;
      chk("burst_m1_dat", m_dat_o[1], DW'(32'hA5A5_0000 + b));
      chk("burst_m1_ack", m_ack[1], 1'b1);
      chk("burst_m3_resp", {m_ack[3], m_err[3], m_rty[3]}, 3'b000);
      chk("burst_m3_dat", m_dat_o[3], '0);
      chk("burst_slave_adr", s_adr, m_adr[1]);
      tick();
    end
    m_cyc[1] = 0; m_stb[1] = 0; s_ack = 0;
    #1 chk("burst_release_cyc", s_cyc, 1'b0);
    chk("burst_release_m3", m_ack[3], 1'b0);
    tick();
    #1 chk("burst_dead_cycle", s_cyc, 1'b0);
    tick();
    #1 chk("burst_m3_granted", {s_cyc, s_adr}, {1'b1, m_adr[3]});
    m_cyc[3] = 0; m_stb[3] = 0;
    tick();

    // slave error on master 2 write, master 3 also requesting
    do_reset();
    m_cyc[2] = 1; m_stb[2] = 1; m_we[2] = 1; m_adr[2] = 32'h0000_1000;
    m_cyc[3] = 1; m_stb[3] = 1;
    tick();
    s_err = 1;
    #1 chk("err_vec_pulse", err_vec(), 4'b0100);
    chk("err_no_ack", ack_vec(), 4'b0000);
    chk("err_slave_wr", {s_we, s_adr}, {1'b1, 32'h0000_1000});
    tick();
    s_err = 0;
    #1 chk("err_one_cycle", err_vec(), 4'b0000);
    m_cyc[2] = 0; m_stb[2] = 0;
    tick();
    tick();
    #1 chk("err_m3_next", {s_cyc, s_adr}, {1'b1, m_adr[3]});
    m_cyc[3] = 0; m_stb[3] = 0;
    tick();

    // asynchronous reset in the middle of a master 0 burst
    do_reset();
    m_cyc[0] = 1; m_stb[0] = 1; m_cyc[1] = 1; m_stb[1] = 1;
    tick();
    s_ack = 1; s_dat_i = 32'h1234_5678;
    #1 chk("rst_burst_active", {s_cyc, s_adr}, {1'b1, m_adr[0]});
    tick();
    #1 rst_n = 0;
    #1 chk("rst_async_zero", any_output(), 1'b0);
    tick();
    tick();
    rst_n = 1; s_ack = 0;
    #1 chk("rst_idle_after", s_cyc, 1'b0);
    tick();
    #1 chk("rst_m0_wins_again", {s_cyc, s_adr}, {1'b1, m_adr[0]});
    idle_inputs();
    tick();
    tick();

    // slave never answers master 1's read
    do_reset();
    m_cyc[1] = 1; m_stb[1] = 1;
    tick();
    for (int k = 1; k <= 12; k++) begin
      logic ef;
`ifdef WB_ARB_TIMEOUT_EN
      ef = (k == TO);
`else
      ef = 1'b0;
`endif
      #1;
      chk("hang_slave_stb", s_stb, !ef);
      chk("hang_slave_cyc", s_cyc, !ef);
      chk("hang_m1_err", m_err[1], ef);
      tick();
    end
    idle_inputs();
    tick();
    tick();

    // randomized traffic against the model
    do_reset();
    hang = 0;
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (m_cyc[i]) begin
          if ($urandom_range(0, 5) == 0) m_cyc[i] = 0;
        end else if ($urandom_range(0, 2) == 0) begin
          m_cyc[i] = 1;
        end
        m_stb[i]   = m_cyc[i] && ($urandom_range(0, 3) != 0);
        m_we[i]    = ($urandom_range(0, 1) == 1);
        m_adr[i]   = $urandom;
        m_dat_i[i] = $urandom;
        m_sel[i]   = SW'($urandom);
      end
      s_dat_i = $urandom;
      s_ack = 0; s_err = 0; s_rty = 0;
      if (hang > 0) begin
        hang--;
      end else begin
        r = $urandom_range(0, 9);
        s_ack = (r <= 3);
        s_err = (r == 4);
        s_rty = (r == 5);
        if ($urandom_range(0, 40) == 0) hang = 12;
      end
      #1;
      model_check();
      model_step();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
